key_repeat: RTL and testbench

KEY_REPEAT -- requirements
Module: key_repeat

---
 rtl/key_repeat.sv | 134 +++++++++++++
 tb/tb_key_repeat.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_repeat.sv
// key_repeat: debounced push-button with one-cycle increment strobes.
// Define KEY_REPEAT_AUTO_EN to enable HELD_WAIT -> HELD_REPEAT auto-repeat.
module key_repeat #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic enable,
  output logic pulse,
  output logic held,
  output logic repeat_active
);

  localparam int MAX_DR =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL =
    (MAX_DR > REPEAT_PERIOD) ?
    MAX_DR : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] DB_END =
    CW'(DEBOUNCE_CYCLES);
`ifdef KEY_REPEAT_AUTO_EN
  localparam logic [CW-1:0] RD_END =
    CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_END =
    CW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD_WAIT,
    HELD_REPEAT,
    RELEASE_DB
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [1:0]      sync;
  logic            pressed;
  logic            fire;

  assign pressed = ~sync[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nx = PRESS_DB;
          cnt_nx   = CW'(1);
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DB_END) begin
          state_nx = HELD_WAIT;
          cnt_nx   = '0;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD_WAIT, HELD_REPEAT: begin
        if (!pressed) begin
          state_nx = RELEASE_DB;
          cnt_nx   = CW'(1);
        end
`ifdef KEY_REPEAT_AUTO_EN
        else if (cnt == ((state == HELD_WAIT) ?
                         RD_END : RP_END)) begin
          state_nx = HELD_REPEAT;
          cnt_nx   = '0;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      RELEASE_DB: begin
        // a low here is a release glitch: resume holding, repeat timer restarts
        if (pressed) begin
          state_nx = HELD_WAIT;
          cnt_nx   = '0;
        end else if (cnt == DB_END) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync          <= 2'b11;
      state         <= IDLE;
      cnt           <= '0;
      pulse         <= 1'b0;
      held          <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= fire & enable;
      held  <= (state_nx == HELD_WAIT) ||
               (state_nx == HELD_REPEAT) ||
               (state_nx == RELEASE_DB);
`ifdef KEY_REPEAT_AUTO_EN
      repeat_active <= (state_nx == HELD_REPEAT);
`else
      repeat_active <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed scenarios plus random key traffic
// compared against a run-length reference model of key_repeat.
module tb_key_repeat;

  localparam int D = 4;
  localparam int R = 8;
  localparam int P = 3;
  localparam int NC = 45;
`ifdef KEY_REPEAT_AUTO_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_n = 1'b1;
  logic enable = 1'b1;
  logic pulse;
  logic held;
  logic repeat_active;

  key_repeat #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(R),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .enable(enable),
    .pulse(pulse),
    .held(held),
    .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // reference model state: run lengths and time since last strobe
  bit kq[$];
  int lows, highs, since;
  bit m_held, m_rep, m_pulse;

  int pq[$];
  bit p_log[NC];
  bit h_log[NC];
  bit r_log[NC];

  task automatic check(input string tag, input int got,
                       input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic model_edge(input bit k, input bit en,
                            input bit rst);
    bit ks, pr, fire;
    fire = 1'b0;
    m_pulse = 1'b0;
    if (!rst) begin
      kq = '{1'b1, 1'b1};
      lows = 0; highs = 0; since = 0;
      m_held = 1'b0; m_rep = 1'b0;
      return;
    end
    kq.push_back(k);
    ks = kq.pop_front();
    pr = !ks;
    if (!m_held) begin
      lows = pr ? lows + 1 : 0;
      if (lows == D + 1) begin
        fire = 1'b1; m_held = 1'b1;
        lows = 0; highs = 0; since = 0; m_rep = 1'b0;
      end
    end else if (!pr) begin
      highs++;
      m_rep = 1'b0;
      if (highs == D + 1) begin
        m_held = 1'b0; highs = 0; lows = 0;
      end
    end else if (highs > 0) begin
      highs = 0; since = 0;
    end else if (AUTO != 0) begin
      since++;
      if (since == (m_rep ? P : R)) begin
        fire = 1'b1; m_rep = 1'b1; since = 0;
      end
    end
    m_pulse = fire & en;
  endtask

  task automatic step(input bit k, input bit en,
                      input bit rst);
    key_n = k; enable = en; reset = rst;
    @(posedge clk);
    #1;
    model_edge(k, en, rst);
    check("pulse", int'(pulse), int'(m_pulse));
    check("held", int'(held), int'(m_held));
    check("repeat_active", int'(repeat_active), int'(m_rep));
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  function automatic bit key_at(input int kind, input int c);
    case (kind)
      0, 4: return (c <= 21) ? 1'b0 : 1'b1;
      1: return (c == 3) ? 1'b1 : 1'b0;
      2: return (c == 10 || c == 11) ? 1'b1 : 1'b0;
      3: return (c <= 40) ? 1'b0 : 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_case(input int kind);
    reset_dut();
    pq.delete();
    for (int c = 0; c < NC; c++) begin
      step(key_at(kind, c), kind != 4,
           !(kind == 5 && c == 15));
      if (pulse) pq.push_back(c);
      p_log[c] = pulse;
      h_log[c] = held;
      r_log[c] = repeat_active;
    end
  endtask

  function automatic int first_after(input int t);
    foreach (pq[i]) if (pq[i] > t) return pq[i];
    return -1;
  endfunction

  int clean_exp[5] = '{6, 14, 17, 20, 23};
  int hcnt;
  int run_len;
  bit rk, ren, rrst;

  initial begin
    reset_dut();
    check("rst_pulse", int'(pulse), 0);
    check("rst_held", int'(held), 0);
    check("rst_rep", int'(repeat_active), 0);

    // clean press
    run_case(0);
    check("clean_npulses", pq.size(), AUTO ? 5 : 1);
    for (int i = 0; i < pq.size() && i < 5; i++)
      check("clean_pulse_at", pq[i], clean_exp[i]);
    check("clean_rep15", int'(r_log[15]), AUTO);
    check("clean_rep23", int'(r_log[23]), AUTO);
    check("clean_rep25", int'(r_log[25]), 0);
    check("clean_held5", int'(h_log[5]), 0);
    check("clean_held6", int'(h_log[6]), 1);
    check("clean_held27", int'(h_log[27]), 1);
    check("clean_held28", int'(h_log[28]), 0);

    // bounce on press
    run_case(1);
    check("bounce_first",
          (pq.size() > 0) ? pq[0] : -1, 10);

    // release glitch
    run_case(2);
    check("glitch_first",
          (pq.size() > 0) ? pq[0] : -1, 6);
    check("glitch_second", first_after(6), AUTO ? 22 : -1);
    hcnt = 0;
    for (int c = 6; c < NC; c++) hcnt += int'(h_log[c]);
    check("glitch_held", hcnt, NC - 6);

    // long hold
    run_case(3);
    check("long_first", (pq.size() > 0) ? pq[0] : -1, 6);
    if (AUTO == 0) check("long_npulses", pq.size(), 1);
    check("long_rep40", int'(r_log[40]), AUTO);

    // enable low
    run_case(4);
    check("noen_npulses", pq.size(), 0);
    check("noen_held5", int'(h_log[5]), 0);
    check("noen_held6", int'(h_log[6]), 1);
    check("noen_held27", int'(h_log[27]), 1);
    check("noen_held28", int'(h_log[28]), 0);

    // reset mid-hold
    run_case(5);
    check("rsthold_p16", int'(p_log[16]), 0);
    check("rsthold_h16", int'(h_log[16]), 0);
    check("rsthold_r16", int'(r_log[16]), 0);
    check("rsthold_p15", int'(p_log[15]), 0);
    check("rsthold_next", first_after(15), 22);

    // random traffic: bouncy and long runs, sparse reset
    reset_dut();
    rk = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rk = ~rk;
      run_len = ($urandom_range(0, 2) == 0) ?
                $urandom_range(1, 3) :
                $urandom_range(1, 40);
      for (int j = 0; j < run_len; j++) begin
        ren = ($urandom_range(0, 9) != 0);
        rrst = ($urandom_range(0, 299) != 0);
        step(rk, ren, rrst);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
